regfile_mp: RTL and testbench

- Parametrised multi-read-port integer register file for the single-cycle RISC-V datapath. Successor to the fixed 32x32, 2-read register file.
- Adds configurable width, depth and read-port count, plus same-cycle write-to-read bypass.
- Adds a sequenced soft-clear engine: an FSM that zeroes one entry per cycle.
- Sits between decode (Rs1/Rs2/Rd fields) and the ALU/writeback mux.

---
 rtl/rv_pkg.sv | 17 +
 rtl/regfile_clear_fsm.sv | 60 ++++++
 rtl/regfile_mp.sv | 113 +++++++++++
 tb/tb_regfile_mp.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared definitions for the integer register file: default sizes,
// soft-clear FSM state encoding and the hard-wired zero register address.
package rv_pkg;

    localparam int XLEN_DEFAULT  = 32;
    localparam int NREGS_DEFAULT = 32;

    // Soft-clear FSM encoding, kept as plain constants for older tooling.
    typedef logic [1:0] clr_state_t;
    localparam clr_state_t ST_IDLE  = 2'd0;
    localparam clr_state_t ST_CLEAR = 2'd1;
    localparam clr_state_t ST_DONE  = 2'd2;

    // Architectural register x0 always reads as zero.
    localparam int X0 = 0;

endpackage

// File: rtl/regfile_clear_fsm.sv
// Soft-clear sequencer: walks clr_ptr from 1 to NREGS-1, zeroing one
// entry per cycle, then raises clr_done for a single cycle.
module regfile_clear_fsm
    import rv_pkg::*;
#(
    parameter int NREGS = NREGS_DEFAULT,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clr_req,
    output clr_state_t      state,
    output logic            clr_busy,
    output logic            clr_done,
    output logic            clr_we,
    output logic [AW-1:0]   clr_addr
);

    localparam logic [AW-1:0] FIRST = AW'(1);
    localparam logic [AW-1:0] LAST  = AW'(NREGS - 1);

    logic [AW-1:0] clr_ptr;

    // State and pointer advance; the pointer parks on the last entry
    // rather than wrapping, so it never points back at x0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            clr_ptr <= FIRST;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (clr_req) begin
                        state   <= ST_CLEAR;
                        clr_ptr <= FIRST;
                    end
                end
                ST_CLEAR: begin
                    if (clr_ptr == LAST) begin
                        state <= ST_DONE;
                    end else begin
                        clr_ptr <= clr_ptr + AW'(1);
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign clr_busy = (state == ST_CLEAR) || (state == ST_DONE);
    assign clr_done = (state == ST_DONE);
    assign clr_we   = (state == ST_CLEAR);
    assign clr_addr = clr_ptr;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port integer register file with same-cycle
// write-to-read bypass and a sequenced soft-clear engine.
// Optional busy-bit scoreboard enabled by defining REGFILE_SCOREBOARD_EN;
// without it rd_busy is tied low and sb_set/sb_addr are ignored.
module regfile_mp
    import rv_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int NREGS = NREGS_DEFAULT,
    parameter int NRD   = 2,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                we,
    input  logic [AW-1:0]       wa,
    input  logic [XLEN-1:0]     wd,
    input  logic                sb_set,
    input  logic [AW-1:0]       sb_addr,
    input  logic                clr_req,
    output logic                clr_busy,
    output logic                clr_done
);

    localparam logic [AW-1:0] ZA = AW'(X0);

    logic [XLEN-1:0] regs [NREGS];

    clr_state_t    state;
    logic          clr_we;
    logic [AW-1:0] clr_addr;
    logic          idle;
    logic          wr_commit;

    regfile_clear_fsm #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_clear_fsm (
        .clk      (clk),
        .reset    (reset),
        .clr_req  (clr_req),
        .state    (state),
        .clr_busy (clr_busy),
        .clr_done (clr_done),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // Writes only land while idle; the clear engine owns the array otherwise.
    assign idle      = (state == ST_IDLE);
    assign wr_commit = we && (wa != ZA) && idle;

    // Storage array: a normal write and a clear write never coincide, and
    // neither can target x0, so entry 0 stays zero forever.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (wr_commit) begin
                regs[wa] <= wd;
            end
            if (clr_we) begin
                regs[clr_addr] <= '0;
            end
        end
    end

`ifdef REGFILE_SCOREBOARD_EN
    logic [NREGS-1:0] busy;

    // Busy bits: producer issue sets, committed write clears (set wins),
    // and the whole scoreboard is wiped when a soft clear finishes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy <= '0;
        end else if (state == ST_DONE) begin
            busy <= '0;
        end else begin
            if (wr_commit) begin
                busy[wa] <= 1'b0;
            end
            if (sb_set && (sb_addr != ZA) && idle) begin
                busy[sb_addr] <= 1'b1;
            end
        end
    end
`else
    logic unused_sb;
    assign unused_sb = ^{sb_set, sb_addr};
    assign rd_busy   = '0;
`endif

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0] ra;
        logic          byp;

        assign ra  = rd_addr[i*AW +: AW];
        assign byp = wr_commit && (wa == ra);

        assign rd_data[i*XLEN +: XLEN] = (ra == ZA) ? '0 :
                                         byp        ? wd :
                                                      regs[ra];
`ifdef REGFILE_SCOREBOARD_EN
        assign rd_busy[i] = (ra != ZA) && busy[ra];
`endif
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed vector table, hand-written
// clear/reset/scoreboard sequences, randomized traffic against a reference
// model, and a second wide/shallow/three-port instance.
module tb_regfile_mp;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // Default instance: XLEN=32, NREGS=32, NRD=2
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        sb_set;
    logic [4:0]  sb_addr;
    logic        clr_req;
    logic        clr_busy;
    logic        clr_done;

    regfile_mp u0 (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_busy(rd_busy), .we(we), .wa(wa), .wd(wd), .sb_set(sb_set),
        .sb_addr(sb_addr), .clr_req(clr_req), .clr_busy(clr_busy),
        .clr_done(clr_done)
    );

    // Second instance: XLEN=64, NREGS=16, NRD=3
    logic [11:0]  p_rd_addr;
    logic [191:0] p_rd_data;
    logic [2:0]   p_rd_busy;
    logic         p_we;
    logic [3:0]   p_wa;
    logic [63:0]  p_wd;
    logic         p_sb_set;
    logic [3:0]   p_sb_addr;
    logic         p_clr_req;
    logic         p_clr_busy;
    logic         p_clr_done;

    regfile_mp #(.XLEN(64), .NREGS(16), .NRD(3)) u1 (
        .clk(clk), .reset(reset), .rd_addr(p_rd_addr), .rd_data(p_rd_data),
        .rd_busy(p_rd_busy), .we(p_we), .wa(p_wa), .wd(p_wd),
        .sb_set(p_sb_set), .sb_addr(p_sb_addr), .clr_req(p_clr_req),
        .clr_busy(p_clr_busy), .clr_done(p_clr_done)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: register contents, busy bits and a clear phase
    // (0 = idle, k in 1..31 = entry k is being zeroed this cycle, 32 = done).
    logic [31:0] mdl [32];
    logic [31:0] mbusy;
    int          phase;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e0;
        logic [31:0] e1;
    } vec_t;
    vec_t tbl [8];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (phase == 0 && we && wa == a) return wd;
        return mdl[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a);
`ifdef REGFILE_SCOREBOARD_EN
        return (a != 5'd0) && mbusy[a];
`else
        return 1'b0;
`endif
    endfunction

    task automatic check_all(input string tag);
        for (int i = 0; i < 2; i++) begin
            check({tag, "/rd_data"}, 64'(rd_data[i*32 +: 32]), 64'(exp_rd(rd_addr[i*5 +: 5])));
            check({tag, "/rd_busy"}, 64'(rd_busy[i]), 64'(exp_busy(rd_addr[i*5 +: 5])));
        end
        check({tag, "/clr_busy"}, 64'(clr_busy), 64'(phase != 0));
        check({tag, "/clr_done"}, 64'(clr_done), 64'(phase == 32));
    endtask

    // Advance one clock; the model applies the rules to the inputs present now.
    task automatic tick();
        logic [31:0] nm [32];
        logic [31:0] nb;
        int          np;
        nm = mdl;
        nb = mbusy;
        if (phase == 0) begin
            if (we && wa != 5'd0) begin
                nm[wa] = wd;
                nb[wa] = 1'b0;
            end
            if (sb_set && sb_addr != 5'd0) nb[sb_addr] = 1'b1;
            np = clr_req ? 1 : 0;
        end else if (phase <= 31) begin
            nm[phase] = 32'h0;
            np = phase + 1;
        end else begin
            nb = 32'h0;
            np = 0;
        end
        @(posedge clk);
        mdl   = nm;
        mbusy = nb;
        phase = np;
        #1;
    endtask

    task automatic idle_inputs();
        we = 1'b0; wa = 5'd0; wd = 32'h0;
        sb_set = 1'b0; sb_addr = 5'd0; clr_req = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
        mbusy = 32'h0;
        phase = 0;
    endtask

    // Run an in-progress clear to completion with a bounded cycle budget.
    task automatic run_clear_to_idle(input string tag);
        for (int k = 0; k < 40 && phase != 0; k++) begin
            rd_addr = {5'(k % 32), 5'(31 - (k % 32))};
            #1;
            check_all(tag);
            tick();
        end
        check({tag, "/ends_idle"}, 64'(clr_busy), 64'(0));
    endtask

    function automatic logic [63:0] pv(input int a);
        if (a == 0) return 64'h0;
        return {32'(a), ~32'(a)};
    endfunction

    initial begin #400000; $display("FAIL timeout: bench exceeded its time budget"); $fatal(1); end

    initial begin
        int busy_cnt;
        int done_cnt;

        tbl[0] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd31, 32'h0,        32'h0};
        tbl[1] = '{1'b1, 5'd3,  32'hDEADBEEF, 5'd3,  5'd5,  32'hDEADBEEF, 32'h0};
        tbl[2] = '{1'b0, 5'd0,  32'h0,        5'd3,  5'd0,  32'hDEADBEEF, 32'h0};
        tbl[3] = '{1'b1, 5'd0,  32'h1234,     5'd0,  5'd3,  32'h0,        32'hDEADBEEF};
        tbl[4] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd31, 32'h0,        32'h0};
        tbl[5] = '{1'b1, 5'd31, 32'hCAFEF00D, 5'd31, 5'd3,  32'hCAFEF00D, 32'hDEADBEEF};
        tbl[6] = '{1'b1, 5'd3,  32'h11111111, 5'd3,  5'd31, 32'h11111111, 32'hCAFEF00D};
        tbl[7] = '{1'b0, 5'd0,  32'h0,        5'd3,  5'd3,  32'h11111111, 32'h11111111};

        idle_inputs();
        rd_addr = {5'd31, 5'd5};
        p_rd_addr = 12'h0; p_we = 1'b0; p_wa = 4'd0; p_wd = 64'h0;
        p_sb_set = 1'b0; p_sb_addr = 4'd0; p_clr_req = 1'b0;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst/clr_busy", 64'(clr_busy), 64'(0));
        check("rst/clr_done", 64'(clr_done), 64'(0));
        check("rst/rd5", 64'(rd_data[31:0]), 64'(0));
        check("rst/rd31", 64'(rd_data[63:32]), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Directed vector table: combinational read then clock
        for (int i = 0; i < 8; i++) begin
            we = tbl[i].we; wa = tbl[i].wa; wd = tbl[i].wd;
            rd_addr = {tbl[i].ra1, tbl[i].ra0};
            #1;
            check($sformatf("vec%0d/p0", i), 64'(rd_data[31:0]), 64'(tbl[i].e0));
            check($sformatf("vec%0d/p1", i), 64'(rd_data[63:32]), 64'(tbl[i].e1));
            check_all($sformatf("vec%0d", i));
            tick();
        end
        idle_inputs();

        // Soft clear: load x1..x31 then clear; a mid-clear write is lost
        for (int i = 1; i < 32; i++) begin
            we = 1'b1; wa = 5'(i); wd = 32'(i) * 32'h11;
            rd_addr = {5'(i), 5'(i - 1)};
            #1;
            check_all("load");
            tick();
        end
        we = 1'b0;
        clr_req = 1'b1;
        #1;
        check_all("clr_start");
        tick();
        clr_req = 1'b0;
        busy_cnt = 0;
        done_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            we = (k == 5); wa = 5'd7; wd = 32'hFFFFFFFF;
            clr_req = (k == 8);
            rd_addr = {5'd7, 5'(k % 32)};
            #1;
            if (clr_busy) busy_cnt++;
            if (clr_done) done_cnt++;
            check_all($sformatf("clr%0d", k));
            tick();
        end
        idle_inputs();
        check("clr/busy_cycles", 64'(busy_cnt), 64'(32));
        check("clr/done_pulses", 64'(done_cnt), 64'(1));
        for (int a = 0; a < 32; a += 2) begin
            rd_addr = {5'(a + 1), 5'(a)};
            #1;
            check($sformatf("clr/zero%0d", a), 64'(rd_data[31:0]), 64'(0));
            check($sformatf("clr/zero%0d", a + 1), 64'(rd_data[63:32]), 64'(0));
            tick();
        end

        // clr_req together with a write: write commits, then gets cleared
        we = 1'b1; wa = 5'd4; wd = 32'hAAAA5555; clr_req = 1'b1;
        rd_addr = {5'd4, 5'd4};
        #1;
        check("clrwr/bypass", 64'(rd_data[31:0]), 64'(32'hAAAA5555));
        check_all("clrwr0");
        tick();
        idle_inputs();
        #1;
        check("clrwr/committed", 64'(rd_data[31:0]), 64'(32'hAAAA5555));
        run_clear_to_idle("clrwr");
        rd_addr = {5'd4, 5'd4};
        #1;
        check("clrwr/overwritten", 64'(rd_data[31:0]), 64'(0));

        // Reset in CLEAR cycle 10: abort, no done, array zero, next clear OK
        we = 1'b1; wa = 5'd20; wd = 32'h2020;
        tick();
        wa = 5'd30; wd = 32'h3030;
        tick();
        we = 1'b0; clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int k = 0; k < 20 && phase != 10; k++) tick();
        check("rstmid/reached10", 64'(phase), 64'(10));
        check("rstmid/busy_before", 64'(clr_busy), 64'(1));
        reset = 1'b1;
        #1;
        model_reset();
        check("rstmid/clr_busy", 64'(clr_busy), 64'(0));
        check("rstmid/clr_done", 64'(clr_done), 64'(0));
        rd_addr = {5'd30, 5'd20};
        #1;
        check("rstmid/x20", 64'(rd_data[31:0]), 64'(0));
        check("rstmid/x30", 64'(rd_data[63:32]), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check_all($sformatf("rstmid_post%0d", k));
        end
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        check("rstmid/reclear", 64'(clr_busy), 64'(1));
        run_clear_to_idle("reclear");

        // Scoreboard
        sb_set = 1'b1; sb_addr = 5'd9; rd_addr = {5'd0, 5'd9};
        #1;
        check_all("sb_pre");
        tick();
        sb_set = 1'b0;
        #1;
`ifdef REGFILE_SCOREBOARD_EN
        check("sb/set9", 64'(rd_busy[0]), 64'(1));
`else
        check("sb/tied0", 64'(rd_busy[0]), 64'(0));
`endif
        we = 1'b1; wa = 5'd9; wd = 32'h99;
        #1;
        check_all("sb_wr");
        tick();
        we = 1'b0;
        #1;
        check("sb/clr9", 64'(rd_busy[0]), 64'(0));
        sb_set = 1'b1; sb_addr = 5'd9; we = 1'b1; wa = 5'd9; wd = 32'h999;
        tick();
        idle_inputs();
        #1;
`ifdef REGFILE_SCOREBOARD_EN
        check("sb/setwins", 64'(rd_busy[0]), 64'(1));
`endif
        check_all("sb_setwins");
        sb_set = 1'b1; sb_addr = 5'd0; rd_addr = {5'd0, 5'd0};
        tick();
        sb_set = 1'b0;
        #1;
        check("sb/x0", 64'(rd_busy), 64'(0));
        rd_addr = {5'd0, 5'd9};
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        run_clear_to_idle("sb_clear");
        rd_addr = {5'd0, 5'd9};
        #1;
        check("sb/wiped", 64'(rd_busy[0]), 64'(0));

        // Randomized traffic against the model
        for (int k = 0; k < 300; k++) begin
            we = 1'($urandom_range(0, 1));
            wa = 5'($urandom);
            wd = $urandom;
            rd_addr = (k % 3 == 0) ? {5'($urandom), wa} : 10'($urandom);
            sb_set = 1'($urandom_range(0, 1));
            sb_addr = 5'($urandom);
            clr_req = ($urandom_range(0, 49) == 0);
            #1;
            check_all($sformatf("rnd%0d", k));
            tick();
        end
        idle_inputs();
        run_clear_to_idle("rnd_tail");

        // Wide instance: three independent ports, bypass, 15+1 clear
        for (int i = 1; i < 16; i++) begin
            p_we = 1'b1; p_wa = 4'(i); p_wd = pv(i);
            @(posedge clk);
            #1;
        end
        p_we = 1'b0;
        for (int t = 0; t < 3; t++) begin
            int a0, a1, a2;
            a0 = (t == 0) ? 6 : (t == 1) ? 1 : 3;
            a1 = (t == 0) ? 15 : (t == 1) ? 9 : 3;
            a2 = (t == 0) ? 0 : (t == 1) ? 12 : 14;
            p_rd_addr = {4'(a2), 4'(a1), 4'(a0)};
            #1;
            check($sformatf("wide%0d/p0", t), p_rd_data[63:0], pv(a0));
            check($sformatf("wide%0d/p1", t), p_rd_data[127:64], pv(a1));
            check($sformatf("wide%0d/p2", t), p_rd_data[191:128], pv(a2));
        end
        p_we = 1'b1; p_wa = 4'd10; p_wd = 64'h0123456789ABCDEF;
        p_rd_addr = {4'd10, 4'd0, 4'd11};
        #1;
        check("wide/bypass", p_rd_data[191:128], 64'h0123456789ABCDEF);
        check("wide/p1_x0", p_rd_data[127:64], 64'h0);
        check("wide/rd_busy", 64'(p_rd_busy), 64'(0));
        @(posedge clk);
        #1;
        p_we = 1'b0;
        p_clr_req = 1'b1;
        @(posedge clk);
        #1;
        p_clr_req = 1'b0;
        busy_cnt = 0;
        done_cnt = 0;
        for (int k = 0; k < 25; k++) begin
            if (p_clr_busy) busy_cnt++;
            if (p_clr_done) done_cnt++;
            @(posedge clk);
            #1;
        end
        check("wide/busy_cycles", 64'(busy_cnt), 64'(16));
        check("wide/done_pulses", 64'(done_cnt), 64'(1));
        p_rd_addr = {4'd15, 4'd10, 4'd1};
        #1;
        check("wide/zero0", p_rd_data[63:0], 64'h0);
        check("wide/zero1", p_rd_data[127:64], 64'h0);
        check("wide/zero2", p_rd_data[191:128], 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
